// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder: PortOut latch, synchronised PortIn and a
// change-capture FIFO, answering single-cycle lw/sw in the issuing cycle.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0800,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] OUT_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        Irq
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  logic [31:0]   port_out_q, port_out_d;
  logic [7:0]    sync1_q, sync2_q, prev_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [1:0] offset;
  logic       change, full, do_push, do_pop, wr_hit;
  logic       unused_addr_bits;

  assign Hit              = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset           = Address[3:2];
  assign unused_addr_bits = ^Address[1:0];
  assign wr_hit           = MemWrite & Hit;

  assign change  = (sync2_q != prev_q);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = MemRead & Hit & (offset == 2'd3) & (count_q != 5'd0);
  // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
  assign do_push = change & (~full | do_pop);

  always_comb begin
    port_out_d = port_out_q;
    if (wr_hit && offset == 2'd0) port_out_d = WriteData;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // Overflow set takes priority over a same-edge STATUS write clear.
    ovf_d = ovf_q;
    if (wr_hit && offset == 2'd2) ovf_d = 1'b0;
    if (change && full && !do_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= OUT_RESET;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      prev_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      if (do_push) fifo_q[wr_ptr_q] <= sync2_q;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && Hit) begin
      case (offset)
        2'd0:    ReadData = port_out_q;
        2'd1:    ReadData = {24'h0, sync2_q};
        2'd2:    ReadData = {26'h0, count_q, ovf_q};
        default: ReadData = (count_q != 5'd0) ? {24'h0, fifo_q[rd_ptr_q]} : 32'h0;
      endcase
    end
  end

  assign PortOut = port_out_q;
  assign Irq     = (count_q != 5'd0) | ovf_q;

endmodule
